fetch_stage: RTL and testbench

- IF stage plus IF/ID pipeline register for the 5-stage MIPS pipeline.
- Owns the PC and drives the instruction-memory address. Captures the fetched word into IF/ID.
- Obeys PC_Write/IF_ID_Write from the hazard detector and Flush from flush detection, which inject a bubble on a taken branch or jump.
- Adds a boot cycle, a stall watchdog and performance counters.

---
 rtl/pipe_pkg.sv | 14 +
 rtl/sat_counter.sv | 19 +
 rtl/fetch_stage.sv | 132 +++++++++++++
 tb/tb_fetch_stage.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared definitions for the 5-stage MIPS pipeline: widths, default NOP and
// fetch-stage state encodings.
package pipe_pkg;

    localparam int unsigned INSTR_W = 32;
    localparam int unsigned ADDR_W  = 32;

    localparam logic [INSTR_W-1:0] NOP_INSTR_DEFAULT = 32'h0000_0000;

    localparam logic [1:0] FETCH_BOOT  = 2'd0;
    localparam logic [1:0] FETCH_RUN   = 2'd1;
    localparam logic [1:0] FETCH_STALL = 2'd2;

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// IF stage with IF/ID pipeline register: PC ownership, stall/flush handling,
// boot bubble, stall watchdog and performance counters.
module fetch_stage
    import pipe_pkg::*;
#(
    parameter logic [ADDR_W-1:0]  RESET_PC  = 32'h0000_0000,
    parameter logic [INSTR_W-1:0] NOP_INSTR = NOP_INSTR_DEFAULT,
    parameter int unsigned        STALL_MAX = 15,
    parameter int unsigned        CNT_W     = 16
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic               PC_Write,
    input  logic               IF_ID_Write,
    input  logic               Flush,
    input  logic [ADDR_W-1:0]  Redirect_PC,
    output logic [ADDR_W-1:0]  Imem_Addr,
    input  logic [INSTR_W-1:0] Imem_Data,
    output logic [ADDR_W-1:0]  PC_ID,
    output logic [ADDR_W-1:0]  PC_Plus4_ID,
    output logic [INSTR_W-1:0] Instruction_ID,
    output logic               Valid_ID,
    output logic               Misalign,
    output logic               Stall_Timeout,
    output logic [CNT_W-1:0]   Stall_Count,
    output logic [CNT_W-1:0]   Flush_Count
);

    localparam int unsigned       RUN_W     = $clog2(STALL_MAX + 2);
    localparam logic [RUN_W-1:0]  RUN_LIMIT = RUN_W'(STALL_MAX + 1);

    logic [1:0]        state, stateNext;
    logic [RUN_W-1:0]  stallRun, stallRunNext;
    logic [ADDR_W-1:0] pc;
    logic              active;
    logic              stallCycle;
    logic              flushCycle;

    assign active     = (state != FETCH_BOOT);
    assign stallCycle = active && !Flush && !PC_Write;
    assign flushCycle = active && Flush;

    assign Imem_Addr   = pc;
    assign PC_Plus4_ID = PC_ID + 32'd4;

    always_comb begin
        stateNext    = state;
        stallRunNext = stallRun;
        case (state)
            FETCH_BOOT: stateNext = FETCH_RUN;
            FETCH_RUN: begin
                if (!Flush && !PC_Write) begin
                    stateNext    = FETCH_STALL;
                    stallRunNext = RUN_W'(1);
                end
            end
            FETCH_STALL: begin
                if (PC_Write || Flush) begin
                    stateNext    = FETCH_RUN;
                    stallRunNext = '0;
                end else if (stallRun != RUN_LIMIT) begin
                    stallRunNext = stallRun + 1'b1;
                end
            end
            default: begin
                stateNext    = FETCH_BOOT;
                stallRunNext = '0;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state         <= FETCH_BOOT;
            stallRun      <= '0;
            Stall_Timeout <= 1'b0;
        end else begin
            state    <= stateNext;
            stallRun <= stallRunNext;
            if (stallRunNext == RUN_LIMIT) begin
                Stall_Timeout <= 1'b1;
            end
        end
    end

    // Flush outranks PC_Write so a taken branch redirects even during a stall
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            pc       <= RESET_PC;
            Misalign <= 1'b0;
        end else if (active) begin
            if (Flush) begin
                pc <= {Redirect_PC[ADDR_W-1:2], 2'b00};
                if (Redirect_PC[1:0] != 2'b00) begin
                    Misalign <= 1'b1;
                end
            end else if (PC_Write) begin
                pc <= pc + 32'd4;
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            Instruction_ID <= NOP_INSTR;
            PC_ID          <= RESET_PC;
            Valid_ID       <= 1'b0;
        end else if (!active || Flush) begin
            Instruction_ID <= NOP_INSTR;
            Valid_ID       <= 1'b0;
        end else if (IF_ID_Write) begin
            Instruction_ID <= Imem_Data;
            PC_ID          <= pc;
            Valid_ID       <= 1'b1;
        end
    end

    sat_counter #(.WIDTH(CNT_W)) uStallCount (
        .clock   (clock),
        .reset_n (reset_n),
        .inc     (stallCycle),
        .count   (Stall_Count)
    );

    sat_counter #(.WIDTH(CNT_W)) uFlushCount (
        .clock   (clock),
        .reset_n (reset_n),
        .inc     (flushCycle),
        .count   (Flush_Count)
    );

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed vector table, hand-written
// corner sequences and randomized traffic against a behavioural model.
module tb_fetch_stage;

    localparam int unsigned CNT_W     = 4;
    localparam int unsigned STALL_MAX = 15;
    localparam logic [31:0] NOP       = 32'h0000_0000;
    localparam logic [31:0] TAG       = 32'hA000_0000;
    localparam int          CNT_MAX   = (1 << CNT_W) - 1;

    logic             clock = 1'b0;
    logic             reset_n = 1'b0;
    logic             PC_Write = 1'b0;
    logic             IF_ID_Write = 1'b0;
    logic             Flush = 1'b0;
    logic [31:0]      Redirect_PC = '0;
    logic [31:0]      Imem_Addr;
    logic [31:0]      Imem_Data;
    logic [31:0]      PC_ID;
    logic [31:0]      PC_Plus4_ID;
    logic [31:0]      Instruction_ID;
    logic             Valid_ID;
    logic             Misalign;
    logic             Stall_Timeout;
    logic [CNT_W-1:0] Stall_Count;
    logic [CNT_W-1:0] Flush_Count;

    assign Imem_Data = Imem_Addr | TAG;

    always #5 clock = ~clock;

    fetch_stage #(
        .RESET_PC  (32'h0000_0000),
        .NOP_INSTR (NOP),
        .STALL_MAX (STALL_MAX),
        .CNT_W     (CNT_W)
    ) dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .PC_Write       (PC_Write),
        .IF_ID_Write    (IF_ID_Write),
        .Flush          (Flush),
        .Redirect_PC    (Redirect_PC),
        .Imem_Addr      (Imem_Addr),
        .Imem_Data      (Imem_Data),
        .PC_ID          (PC_ID),
        .PC_Plus4_ID    (PC_Plus4_ID),
        .Instruction_ID (Instruction_ID),
        .Valid_ID       (Valid_ID),
        .Misalign       (Misalign),
        .Stall_Timeout  (Stall_Timeout),
        .Stall_Count    (Stall_Count),
        .Flush_Count    (Flush_Count)
    );

    int nChecks = 0;
    int nFails  = 0;

    // Behavioural model state
    logic [31:0] mPc, mPcId, mInstr;
    bit          mValid, mMis, mTo, mBoot;
    int          mRun, mStallCnt, mFlushCnt;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic modelReset();
        mPc = 32'h0; mPcId = 32'h0; mInstr = NOP; mValid = 0;
        mMis = 0; mTo = 0; mBoot = 1; mRun = 0; mStallCnt = 0; mFlushCnt = 0;
    endtask

    task automatic modelStep();
        if (mBoot) begin
            mBoot = 0; mInstr = NOP; mValid = 0;
        end else begin
            if (!Flush && !PC_Write) begin
                if (mRun < STALL_MAX + 1) mRun++;
                if (mStallCnt < CNT_MAX) mStallCnt++;
            end else begin
                mRun = 0;
            end
            if (mRun >= STALL_MAX + 1) mTo = 1;
            if (Flush && mFlushCnt < CNT_MAX) mFlushCnt++;
            if (Flush) begin
                mInstr = NOP; mValid = 0;
            end else if (IF_ID_Write) begin
                mInstr = mPc | TAG; mPcId = mPc; mValid = 1;
            end
            if (Flush) begin
                mPc = Redirect_PC & ~32'd3;
                if (Redirect_PC[1:0] != 2'b00) mMis = 1;
            end else if (PC_Write) begin
                mPc = mPc + 32'd4;
            end
        end
    endtask

    task automatic checkAll();
        check("Imem_Addr", Imem_Addr, mPc);
        check("PC_ID", PC_ID, mPcId);
        check("PC_Plus4_ID", PC_Plus4_ID, mPcId + 32'd4);
        check("Instruction_ID", Instruction_ID, mInstr);
        check("Valid_ID", {31'b0, Valid_ID}, {31'b0, mValid});
        check("Misalign", {31'b0, Misalign}, {31'b0, mMis});
        check("Stall_Timeout", {31'b0, Stall_Timeout}, {31'b0, mTo});
        check("Stall_Count", 32'(Stall_Count), 32'(mStallCnt));
        check("Flush_Count", 32'(Flush_Count), 32'(mFlushCnt));
    endtask

    task automatic cycle();
        @(posedge clock);
        modelStep();
        #1;
        checkAll();
    endtask

    task automatic drive(input bit pw, input bit iw, input bit fl, input logic [31:0] rd);
        PC_Write = pw; IF_ID_Write = iw; Flush = fl; Redirect_PC = rd;
    endtask

    task automatic doReset();
        @(negedge clock);
        reset_n = 1'b0;
        modelReset();
        #12;
        @(negedge clock);
        reset_n = 1'b1;
        #1;
        checkAll();
    endtask

    typedef struct {
        bit          pw, iw, fl;
        logic [31:0] redir, expPc, expPcId, expInstr;
        bit          expValid, expMis;
    } vec_t;

    vec_t vecs[15];

    initial begin
        // Boot cycle inputs are deliberately hostile: they must be ignored
        vecs[0]  = '{0, 0, 1, 32'h80, 32'h00, 32'h00, NOP,          0, 0};
        vecs[1]  = '{1, 1, 0, 32'h00, 32'h04, 32'h00, 32'hA000_0000, 1, 0};
        vecs[2]  = '{1, 1, 0, 32'h00, 32'h08, 32'h04, 32'hA000_0004, 1, 0};
        vecs[3]  = '{1, 1, 0, 32'h00, 32'h0C, 32'h08, 32'hA000_0008, 1, 0};
        vecs[4]  = '{1, 1, 0, 32'h00, 32'h10, 32'h0C, 32'hA000_000C, 1, 0};
        vecs[5]  = '{0, 0, 0, 32'h00, 32'h10, 32'h0C, 32'hA000_000C, 1, 0};
        vecs[6]  = '{0, 0, 0, 32'h00, 32'h10, 32'h0C, 32'hA000_000C, 1, 0};
        vecs[7]  = '{0, 0, 0, 32'h00, 32'h10, 32'h0C, 32'hA000_000C, 1, 0};
        vecs[8]  = '{1, 1, 0, 32'h00, 32'h14, 32'h10, 32'hA000_0010, 1, 0};
        vecs[9]  = '{0, 0, 1, 32'h40, 32'h40, 32'h10, NOP,          0, 0};
        vecs[10] = '{1, 1, 0, 32'h00, 32'h44, 32'h40, 32'hA000_0040, 1, 0};
        vecs[11] = '{1, 1, 1, 32'h43, 32'h40, 32'h40, NOP,          0, 1};
        vecs[12] = '{1, 1, 1, 32'h80, 32'h80, 32'h40, NOP,          0, 1};
        vecs[13] = '{1, 0, 0, 32'h00, 32'h84, 32'h40, NOP,          0, 1};
        vecs[14] = '{0, 1, 0, 32'h00, 32'h84, 32'h84, 32'hA000_0084, 1, 1};

        doReset();
        for (int i = 0; i < 15; i++) begin
            drive(vecs[i].pw, vecs[i].iw, vecs[i].fl, vecs[i].redir);
            cycle();
            check($sformatf("vec%0d_pc", i), Imem_Addr, vecs[i].expPc);
            check($sformatf("vec%0d_pcid", i), PC_ID, vecs[i].expPcId);
            check($sformatf("vec%0d_instr", i), Instruction_ID, vecs[i].expInstr);
            check($sformatf("vec%0d_valid", i), {31'b0, Valid_ID}, {31'b0, vecs[i].expValid});
            check($sformatf("vec%0d_mis", i), {31'b0, Misalign}, {31'b0, vecs[i].expMis});
            if (i == 7)  check("stall3_count", 32'(Stall_Count), 32'd3);
            if (i == 9)  check("flush1_count", 32'(Flush_Count), 32'd1);
        end

        // Watchdog: end the current stall, then hold a fresh one for 16 cycles
        drive(1, 1, 0, 0);
        cycle();
        drive(0, 0, 0, 0);
        for (int i = 1; i <= 16; i++) begin
            cycle();
            check($sformatf("timeout_stall%0d", i), {31'b0, Stall_Timeout}, (i == 16) ? 32'd1 : 32'd0);
        end
        check("stall_count_sat", 32'(Stall_Count), 32'(CNT_MAX));
        drive(1, 1, 0, 0);
        cycle();
        check("timeout_sticky", {31'b0, Stall_Timeout}, 32'd1);

        // PC wrap and PC_Plus4_ID wrap
        drive(1, 1, 1, 32'hFFFF_FFFC);
        cycle();
        check("wrap_pc_top", Imem_Addr, 32'hFFFF_FFFC);
        drive(1, 1, 0, 0);
        cycle();
        check("wrap_pc_zero", Imem_Addr, 32'h0);
        check("wrap_pcid", PC_ID, 32'hFFFF_FFFC);
        check("wrap_plus4", PC_Plus4_ID, 32'h0);

        // Asynchronous reset in the middle of a cycle
        drive(0, 0, 1, 32'h123);
        @(posedge clock);
        modelStep();
        #3;
        reset_n = 1'b0;
        #1;
        modelReset();
        checkAll();
        check("async_pc", Imem_Addr, 32'h0);
        check("async_timeout", {31'b0, Stall_Timeout}, 32'd0);
        check("async_flushcnt", 32'(Flush_Count), 32'd0);
        #10;
        @(negedge clock);
        reset_n = 1'b1;
        #1;
        checkAll();

        // Random traffic, general mix
        for (int i = 0; i < 3000; i++) begin
            logic [31:0] rd;
            rd = $urandom;
            if ($urandom_range(3) != 0) rd[1:0] = 2'b00;
            drive($urandom_range(3) != 0, $urandom_range(3) != 0, $urandom_range(7) == 0, rd);
            cycle();
        end

        // Random traffic biased toward long stalls
        doReset();
        for (int i = 0; i < 3000; i++) begin
            logic [31:0] rd;
            rd = $urandom;
            rd[1:0] = 2'b00;
            drive($urandom_range(19) == 0, $urandom_range(1) == 0, $urandom_range(39) == 0, rd);
            cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "time limit");
    end

endmodule
